// File: rtl/life_pattern_loader.sv
// life_pattern_loader: streams a 16-cell seed into life_array_4x4, then issues spaced run pulses
module life_pattern_loader #(
  parameter int GEN_PERIOD = 4,
  parameter int PW = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] pattern,
  input  logic [7:0]  gens,
  output logic [1:0]  row,
  output logic [1:0]  col,
  output logic        val,
  output logic        write_enb,
  output logic        run,
  output logic        busy,
  output logic        done,
  output logic [7:0]  gens_left
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;
  localparam logic [PW-1:0] LAST = PW'(GEN_PERIOD - 1);
  state_t state, state_d;
  logic [3:0] idx, idx_d;
  logic [PW-1:0] cnt, cnt_d;
  logic [15:0] pat_q, pat_d;
  logic [1:0] row_d, col_d;
  logic val_d, we_d, run_d, busy_d, done_d;
  logic [7:0] gens_d;
  // next state and next registered outputs; outputs for a cycle are computed one edge ahead
  always_comb begin
    state_d = state;
    idx_d = idx;
    cnt_d = cnt;
    pat_d = pat_q;
    gens_d = gens_left;
    row_d = row;
    col_d = col;
    val_d = val;
    we_d = 1'b0;
    run_d = 1'b0;
    done_d = 1'b0;
    case (state)
      IDLE: if (start && !abort) begin
        state_d = LOAD;
        pat_d = pattern;
        gens_d = gens;
        idx_d = 4'd0;
        we_d = 1'b1;
        row_d = 2'd0;
        col_d = 2'd0;
        val_d = pattern[0];
      end
      LOAD: if (idx == 4'd15) begin
        state_d = gens_left == 8'd0 ? FIN : RUN;
        done_d = gens_left == 8'd0;
        cnt_d = '0;
        run_d = gens_left != 8'd0 && GEN_PERIOD == 1;
        gens_d = gens_left - 8'(run_d);
      end else begin
        idx_d = idx + 4'd1;
        we_d = 1'b1;
        row_d = idx_d[3:2];
        col_d = idx_d[1:0];
        val_d = pat_q[idx_d];
      end
      RUN: if (run && gens_left == 8'd0) begin
        state_d = FIN;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt == LAST ? '0 : cnt + 1'b1;
        run_d = cnt_d == LAST && gens_left != 8'd0;
        gens_d = gens_left - 8'(run_d);
      end
      default: state_d = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_d = IDLE;
      we_d = 1'b0;
      run_d = 1'b0;
      done_d = 1'b0;
      gens_d = gens_left;
    end
    busy_d = state_d != IDLE;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      pat_q <= '0;
      row <= '0;
      col <= '0;
      val <= 1'b0;
      write_enb <= 1'b0;
      run <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      gens_left <= '0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      cnt <= cnt_d;
      pat_q <= pat_d;
      row <= row_d;
      col <= col_d;
      val <= val_d;
      write_enb <= we_d;
      run <= run_d;
      busy <= busy_d;
      done <= done_d;
      gens_left <= gens_d;
    end
  end
endmodule

// File: tb/tb_life_pattern_loader.sv
// tb_life_pattern_loader: checks load/run traces of life_pattern_loader against a timeline model and a shadow life array
module tb_life_pattern_loader;
  localparam int GP = 4;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [15:0] pattern = '0;
  logic [7:0] gens = '0;
  logic [1:0] row, col;
  logic val, write_enb, run, busy, done;
  logic [7:0] gens_left;
  logic [15:0] alive;
  int errors = 0, checks = 0;

  life_pattern_loader #(.GEN_PERIOD(GP), .PW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern), .gens(gens),
    .row(row), .col(col), .val(val), .write_enb(write_enb), .run(run), .busy(busy),
    .done(done), .gens_left(gens_left)
  );

  always #5 clk = ~clk;

  // one Conway generation on a 4x4 board with dead cells beyond the edge
  function automatic logic [15:0] step(input logic [15:0] a);
    logic [15:0] n;
    int k, rr, cc;
    n = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < 4 && cc >= 0 && cc < 4 && a[4*rr+cc]) k++;
          end
        n[4*r+c] = a[4*r+c] ? (k == 2 || k == 3) : (k == 3);
      end
    return n;
  endfunction

  // shadow of the downstream array, driven only by the DUT outputs
  always @(posedge clk) begin
    if (reset) alive <= '0;
    else if (write_enb) alive[4*row+col] <= val;
    else if (run) alive <= step(alive);
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({row, col, val, write_enb, run, busy, done, gens_left} !== 17'b0) begin
      errors++;
      $display("FAIL reset outputs got=%h want=0", {row, col, val, write_enb, run, busy, done, gens_left});
    end
    reset = 1'b0;
  endtask

  // one full operation from the IDLE cycle where start is raised to the first IDLE cycle after done
  task automatic test_op(input logic [15:0] p, input logic [7:0] g, input bit noise);
    int last, pulses, cv;
    logic [16:0] want, got;
    last = 16 + int'(g) * GP;
    pattern = p;
    gens = g;
    start = 1'b1;
    for (int c = 0; c <= last + 1; c++) begin
      @(negedge clk);
      cv = c < 16 ? c : 15;
      pulses = c < 16 ? 0 : ((c - 15) / GP > int'(g) ? int'(g) : (c - 15) / GP);
      want = {2'(cv >> 2), 2'(cv & 3), p[cv], c < 16,
              g != 0 && c >= 16 && (c - 15) % GP == 0 && (c - 15) / GP <= int'(g),
              c <= last, c == last, 8'(int'(g) - pulses)};
      got = {row, col, val, write_enb, run, busy, done, gens_left};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL op p=%h g=%0d cycle=%0d got=%h want=%h (row,col,val,we,run,busy,done,gens_left)", p, g, c, got, want);
      end
      start = noise && c < last ? 1'($urandom) : 1'b0;
      pattern = noise ? 16'($urandom) : p;
      gens = noise ? 8'($urandom) : g;
    end
  endtask

  task automatic test_load_only();
    test_op(16'h0001, 8'd0, 1'b0);
    checks++;
    if (alive !== 16'h0001) begin errors++; $display("FAIL load_only alive got=%h want=0001", alive); end
  endtask

  task automatic test_block();
    test_op(16'h0660, 8'd3, 1'b0);
    checks++;
    if (alive !== 16'h0660) begin errors++; $display("FAIL block alive got=%h want=0660", alive); end
  endtask

  task automatic test_blinker();
    test_op(16'h00E0, 8'd1, 1'b0);
    checks++;
    if (alive !== 16'h0444) begin errors++; $display("FAIL blinker1 alive got=%h want=0444", alive); end
    test_op(16'h00E0, 8'd2, 1'b0);
    checks++;
    if (alive !== 16'h00E0) begin errors++; $display("FAIL blinker2 alive got=%h want=00e0", alive); end
  endtask

  task automatic test_abort();
    test_op(16'hFFFF, 8'd0, 1'b0);
    pattern = 16'h0000;
    gens = 8'd7;
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (write_enb !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL abort_load cycle=%0d got we=%b busy=%b want we=1 busy=1", c, write_enb, busy);
      end
      abort = c == 4;
    end
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({write_enb, run, busy, done, gens_left} !== {4'b0, 8'd7}) begin
      errors++;
      $display("FAIL abort_state got=%h want=%h", {write_enb, run, busy, done, gens_left}, {4'b0, 8'd7});
    end
    checks++;
    if (alive !== 16'hFFE0) begin errors++; $display("FAIL abort_cells alive got=%h want=ffe0", alive); end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || write_enb !== 1'b0) begin
      errors++;
      $display("FAIL abort_wins got busy=%b we=%b want 0 0", busy, write_enb);
    end
    test_op(16'h8421, 8'd1, 1'b0);
    checks++;
    if (alive !== step(16'h8421)) begin errors++; $display("FAIL after_abort alive got=%h want=%h", alive, step(16'h8421)); end
  endtask

  task automatic test_start_during_run();
    test_op(16'h0660, 8'd2, 1'b1);
    checks++;
    if (alive !== 16'h0660) begin errors++; $display("FAIL start_ignored alive got=%h want=0660", alive); end
  endtask

  task automatic test_reset_mid_run();
    int stray;
    pattern = 16'h00E0;
    gens = 8'd5;
    start = 1'b1;
    for (int c = 0; c <= 15 + 3 * GP; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (gens_left !== 8'd2 || run !== 1'b1) begin
      errors++;
      $display("FAIL mid_run gens_left got=%0d run=%b want 2 1", gens_left, run);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({row, col, val, write_enb, run, busy, done, gens_left} !== 17'b0) begin
      errors++;
      $display("FAIL mid_run_reset outputs got=%h want=0", {row, col, val, write_enb, run, busy, done, gens_left});
    end
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 5 * GP; c++) begin
      @(negedge clk);
      if (run || busy || done) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL post_reset activity got=%0d cycles want=0", stray); end
  endtask

  task automatic test_random();
    logic [15:0] p, want;
    logic [7:0] g;
    for (int i = 0; i < 8; i++) begin
      p = 16'($urandom);
      g = i == 7 ? 8'd255 : 8'($urandom_range(0, 5));
      test_op(p, g, 1'($urandom_range(0, 1)));
      want = p;
      for (int k = 0; k < int'(g); k++) want = step(want);
      checks++;
      if (alive !== want) begin errors++; $display("FAIL random p=%h g=%0d alive got=%h want=%h", p, g, alive, want); end
    end
  endtask

  initial begin
    test_reset();
    test_load_only();
    test_block();
    test_blinker();
    test_abort();
    test_start_during_run();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/life_pattern_loader.md
Name: life_pattern_loader

Overview:
- Upstream controller for life_array_4x4: loads a 16-bit seed pattern into the array one cell per clock via row/col/val/write_enb.
- Then issues a programmed number of single-cycle run pulses, spaced GEN_PERIOD clocks apart, and signals completion.
- Sits between the host/switch interface and the array; its outputs connect straight to the array's write and run inputs.

Parameters:
- GEN_PERIOD, 4, clocks between successive run pulses (minimum 1); at 1, run is high every RUN cycle.
- PW, 16, width of the period counter; must satisfy GEN_PERIOD <= 2^PW.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- start  in  1  request load+run; sampled only in IDLE
- abort  in  1  cancel current operation; return to IDLE
- pattern  in  16  seed; bit 4*r+c = cell (row r, col c), same mapping as array alive
- gens  in  8  number of generations to run after load (0 = load only)
- row  out  2  cell row to array
- col  out  2  cell column to array
- val  out  1  cell value to array
- write_enb  out  1  array write strobe
- run  out  1  one-cycle generation step strobe to array
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on normal completion
- gens_left  out  8  generations still to be issued

Behaviour:
- All outputs registered. Reset values: row=0, col=0, val=0, write_enb=0, run=0, busy=0, done=0, gens_left=0; state=IDLE; index and period counters=0.
- States: IDLE, LOAD, RUN, FIN.
- IDLE:
  - On start=1 and abort=0, latch pattern into pat_q and gens into gens_left; index=0; go LOAD.
  - Inputs are latched at the accept edge; later changes to pattern/gens have no effect.
- LOAD:
  - Cycle n after accept (n=0..15): write_enb=1, row=n[3:2], col=n[1:0], val=pat_q[n].
  - Exactly 16 write cycles, with no gaps.
  - After n=15: if gens_left==0 go FIN, else go RUN with period counter=0; write_enb=0 from that cycle.
- RUN:
  - Period counter increments each cycle.
  - When counter==GEN_PERIOD-1: run=1 for that cycle, counter->0, gens_left decrements.
  - First run pulse is the GEN_PERIOD-th cycle in RUN.
  - When the pulse that takes gens_left 1->0 is issued, go FIN next cycle.
  - row/col/val hold last values (3,3,pat_q[15]); write_enb=0.
- FIN: done=1 for exactly one cycle; busy still 1; next state IDLE (busy=0).
- start while busy is ignored (no queueing); start held high after FIN restarts a new load the cycle after returning to IDLE.
- abort=1 in any non-IDLE state:
  - Next edge: state IDLE; write_enb=0, run=0, busy=0; no done pulse.
  - gens_left keeps its value at abort time.
  - Cells already written stay written (no rollback).
- abort and start together in IDLE: abort wins; stay IDLE.
- reset overrides everything, including mid-LOAD or mid-RUN; it takes effect at the same edge it is sampled.
- run and write_enb are never high in the same cycle.
- gens=255 runs 255 pulses. The counter never wraps gens_left below 0.

Test Plan:
- Reset, start with pattern=16'h0001, gens=0 -> 16 write cycles; val=1 only at row=0,col=0; done pulse one cycle after last write; array alive==16'h0001; run never asserted.
- pattern=16'h0660 (block), gens=3, GEN_PERIOD=4 -> 16 writes then run pulses at RUN cycles 4, 8 and 12; gens_left 3->2->1->0; done 1 cycle after third pulse; alive stays 16'h0660.
- pattern=16'h0270 (blinker, row 1 cols 1..3 -> adjust to 16'h00E0), gens=1 -> alive after run equals the vertical blinker 16'h0444; gens=2 returns to 16'h00E0.
- abort asserted at LOAD cycle 5 -> write_enb low next cycle; busy=0; no done; cells 0..4 written, remainder unchanged; next start accepted.
- start pulsed during RUN with different pattern -> ignored; original gens count completes; pattern not reloaded.
- reset asserted mid-RUN with gens_left=2 -> all outputs return to reset values at that edge; no further run pulses.
